// File: rtl/automata_pkg.sv
// Shared types and constants for the table-programmed Mealy automaton.
// Defaults here match the default parameters of table_automata.
package automata_pkg;

    localparam int IN_W_D     = 8;
    localparam int OUT_W_D    = 8;
    localparam int N_STATES_D = 6;
    localparam int SW_D       = $clog2(N_STATES_D);
    localparam int N_RULES_D  = 4;
    localparam int RW_D       = $clog2(N_RULES_D);
    localparam int CNT_W_D    = 16;

    typedef logic [SW_D-1:0] state_t;

    // Packed rule layout, MSB first: {valid, mask, value, ns, out}
    typedef struct packed {
        logic               valid;
        logic [IN_W_D-1:0]  mask;
        logic [IN_W_D-1:0]  value;
        state_t             ns;
        logic [OUT_W_D-1:0] out;
    } rule_t;

    localparam logic [OUT_W_D-1:0] OUT_ZERO = '0;

endpackage

// File: rtl/automata_rule_match.sv
// Priority matcher over one state's rules; lowest-index matching rule wins.
// Ports: rules (N_RULES packed entries), u (input) -> hit, hit_rule, ns, out.
module automata_rule_match
    import automata_pkg::*;
#(
    parameter int IN_W    = IN_W_D,
    parameter int OUT_W   = OUT_W_D,
    parameter int SW      = SW_D,
    parameter int N_RULES = N_RULES_D,
    parameter int RW      = RW_D,
    parameter int RULE_W  = 1 + 2*IN_W + SW + OUT_W
) (
    input  logic [N_RULES-1:0][RULE_W-1:0] rules,
    input  logic [IN_W-1:0]                u,
    output logic                           hit,
    output logic [RW-1:0]                  hit_rule,
    output logic [SW-1:0]                  ns,
    output logic [OUT_W-1:0]               out
);

    localparam int NS_LSB = OUT_W;
    localparam int V_LSB  = OUT_W + SW;
    localparam int M_LSB  = V_LSB + IN_W;

    logic [IN_W-1:0] msk;
    logic [IN_W-1:0] val;

    // Scan from lowest priority upward so the last assignment is rule 0.
    always_comb begin
        hit      = 1'b0;
        hit_rule = '0;
        ns       = '0;
        out      = OUT_W'(OUT_ZERO);
        msk      = '0;
        val      = '0;
        for (int r = N_RULES - 1; r >= 0; r--) begin
            msk = rules[r][M_LSB +: IN_W];
            val = rules[r][V_LSB +: IN_W];
            if (rules[r][RULE_W-1] && ((u & msk) == (val & msk))) begin
                hit      = 1'b1;
                hit_rule = RW'(r);
                ns       = rules[r][NS_LSB +: SW];
                out      = rules[r][0 +: OUT_W];
            end
        end
    end

endmodule

// File: rtl/table_automata.sv
// Table-programmed Mealy automaton with enable, runtime rule writes and a
// taken-transition counter. Ports: clk, rst (sync, active-low), EN, U,
// cfg_we/cfg_state/cfg_rule/cfg_data (rule write), C, state, next_state,
// hit, hit_rule, trans_cnt.
module table_automata
    import automata_pkg::*;
#(
    parameter int IN_W     = IN_W_D,
    parameter int OUT_W    = OUT_W_D,
    parameter int N_STATES = N_STATES_D,
    parameter int SW       = $clog2(N_STATES),
    parameter int N_RULES  = N_RULES_D,
    parameter int RW       = $clog2(N_RULES),
    parameter int CNT_W    = CNT_W_D,
    parameter int RULE_W   = 1 + 2*IN_W + SW + OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic [IN_W-1:0]   U,
    input  logic              cfg_we,
    input  logic [SW-1:0]     cfg_state,
    input  logic [RW-1:0]     cfg_rule,
    input  logic [RULE_W-1:0] cfg_data,
    output logic [OUT_W-1:0]  C,
    output logic [SW-1:0]     state,
    output logic [SW-1:0]     next_state,
    output logic              hit,
    output logic [RW-1:0]     hit_rule,
    output logic [CNT_W-1:0]  trans_cnt
);

    logic [N_STATES-1:0][N_RULES-1:0][RULE_W-1:0] rule_q;
    logic [N_RULES-1:0][RULE_W-1:0]               cur_rules;

    logic             m_hit;
    logic [RW-1:0]    m_rule;
    logic [SW-1:0]    m_ns;
    logic [OUT_W-1:0] m_out;

    // Select the current state's rules without an out-of-range index.
    always_comb begin
        cur_rules = '0;
        for (int s = 0; s < N_STATES; s++) begin
            if (state == SW'(s)) begin
                cur_rules = rule_q[s];
            end
        end
    end

    automata_rule_match #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SW      (SW),
        .N_RULES (N_RULES),
        .RW      (RW),
        .RULE_W  (RULE_W)
    ) u_match (
        .rules    (cur_rules),
        .u        (U),
        .hit      (m_hit),
        .hit_rule (m_rule),
        .ns       (m_ns),
        .out      (m_out)
    );

    // Illegal target state falls back to state 0 with zero output;
    // hit still reports that a rule fired.
    always_comb begin
        next_state = state;
        C          = OUT_W'(OUT_ZERO);
        if (m_hit) begin
            if (int'(m_ns) >= N_STATES) begin
                next_state = '0;
            end else begin
                next_state = m_ns;
                C          = m_out;
            end
        end
    end

    assign hit      = m_hit;
    assign hit_rule = m_rule;

    // Table writes land after this edge, so this cycle evaluates old entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= '0;
            trans_cnt <= '0;
            rule_q    <= '0;
        end else begin
            if (EN) begin
                state <= next_state;
                if (m_hit && (next_state != state)) begin
                    trans_cnt <= trans_cnt + CNT_W'(1);
                end
            end
            for (int s = 0; s < N_STATES; s++) begin
                for (int r = 0; r < N_RULES; r++) begin
                    if (cfg_we && cfg_state == SW'(s) &&
                        cfg_rule == RW'(r)) begin
                        rule_q[s][r] <= cfg_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_table_automata.sv
// Self-checking bench for table_automata: vector table plus scoreboard queue.
// A second instance with a 4-bit counter shares all inputs to exercise wrap.
module tb_table_automata;
    import automata_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        EN;
    logic [7:0]  U;
    logic        cfg_we;
    logic [2:0]  cfg_state;
    logic [1:0]  cfg_rule;
    logic [27:0] cfg_data;

    logic [7:0]  C,  c4;
    logic [2:0]  state, next_state, st4, ns4;
    logic        hit, hit4;
    logic [1:0]  hit_rule, hr4;
    logic [15:0] trans_cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    table_automata dut (
        .clk(clk), .rst(rst), .EN(EN), .U(U),
        .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_rule(cfg_rule),
        .cfg_data(cfg_data), .C(C), .state(state), .next_state(next_state),
        .hit(hit), .hit_rule(hit_rule), .trans_cnt(trans_cnt)
    );

    table_automata #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .EN(EN), .U(U),
        .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_rule(cfg_rule),
        .cfg_data(cfg_data), .C(c4), .state(st4), .next_state(ns4),
        .hit(hit4), .hit_rule(hr4), .trans_cnt(cnt4)
    );

    typedef struct {
        logic [7:0]  u;
        logic        en;
        logic        we;
        logic [2:0]  cs;
        logic [1:0]  cr;
        logic [27:0] cd;
        logic [7:0]  c;
        logic [2:0]  ns;
        logic        h;
        logic [1:0]  r;
        logic [2:0]  st;
        logic [15:0] cnt;
    } vec_t;

    vec_t tv[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [27:0] rl(input logic [7:0] m,
        input logic [7:0] v, input logic [2:0] ns, input logic [7:0] o);
        rule_t x;
        x.valid = 1'b1; x.mask = m; x.value = v; x.ns = ns; x.out = o;
        return x;
    endfunction

    function automatic vec_t mk(input logic [7:0] u, input logic en,
        input logic we, input logic [2:0] cs, input logic [1:0] cr,
        input logic [27:0] cd, input logic [7:0] c, input logic [2:0] ns,
        input logic h, input logic [1:0] r, input logic [2:0] st,
        input logic [15:0] cnt);
        vec_t x;
        x.u = u; x.en = en; x.we = we; x.cs = cs; x.cr = cr; x.cd = cd;
        x.c = c; x.ns = ns; x.h = h; x.r = r; x.st = st; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string nm, input int idx,
        input logic [15:0] act, input logic [15:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, req);
        end
    endtask

    // Drive one cycle at posedge+1, push expectation, compare at negedge.
    task automatic cyc(input vec_t v);
        vec_t e;
        U = v.u; EN = v.en; cfg_we = v.we;
        cfg_state = v.cs; cfg_rule = v.cr; cfg_data = v.cd;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk("C", n_vec, 16'(C), 16'(e.c));
        chk("next_state", n_vec, 16'(next_state), 16'(e.ns));
        chk("hit", n_vec, 16'(hit), 16'(e.h));
        chk("hit_rule", n_vec, 16'(hit_rule), 16'(e.r));
        chk("state", n_vec, 16'(state), 16'(e.st));
        chk("trans_cnt", n_vec, trans_cnt, e.cnt);
        chk("state4", n_vec, 16'(st4), 16'(e.st));
        chk("trans_cnt4", n_vec, 16'(cnt4), 16'(e.cnt[3:0]));
        n_vec++;
        @(posedge clk); #1;
    endtask

    // Reset while EN and a table write are active: both must be overridden.
    task automatic do_reset(input int n);
        rst = 1'b0; EN = 1'b1; U = 8'h00;
        cfg_we = 1'b1; cfg_state = 3'd0; cfg_rule = 2'd0;
        cfg_data = rl(8'h00, 8'h00, 3'd3, 8'hEE);
        repeat (n) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; cfg_we = 1'b0;
    endtask

    logic [2:0] s;

    initial begin
        rst = 1'b0; EN = 1'b0; U = '0; cfg_we = 1'b0;
        cfg_state = '0; cfg_rule = '0; cfg_data = '0;
        @(posedge clk); #1;
        do_reset(2);

        // Reset then idle with all-ones input
        for (int i = 0; i < 10; i++)
            cyc(mk(8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));

        // Basic, priority, enable gating, collision, illegal ns
        tv.push_back(mk(8'h00, 0, 1, 0, 0, rl(8'h03, 8'h00, 5, 8'h91),
                        8'h00, 0, 0, 0, 0, 0));
        tv.push_back(mk(8'h01, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tv.push_back(mk(8'h00, 1, 0, 0, 0, 0, 8'h91, 5, 1, 0, 0, 0));
        tv.push_back(mk(8'h00, 0, 1, 5, 0, rl(8'h02, 8'h02, 1, 8'h7F),
                        8'h00, 5, 0, 0, 5, 1));
        tv.push_back(mk(8'h02, 0, 1, 5, 1, rl(8'h00, 8'h00, 4, 8'hB7),
                        8'h7F, 1, 1, 0, 5, 1));
        tv.push_back(mk(8'h00, 0, 0, 0, 0, 0, 8'hB7, 4, 1, 1, 5, 1));
        tv.push_back(mk(8'h02, 0, 0, 0, 0, 0, 8'h7F, 1, 1, 0, 5, 1));
        tv.push_back(mk(8'h00, 0, 0, 0, 0, 0, 8'hB7, 4, 1, 1, 5, 1));
        tv.push_back(mk(8'h02, 0, 0, 0, 0, 0, 8'h7F, 1, 1, 0, 5, 1));
        tv.push_back(mk(8'h00, 0, 0, 0, 0, 0, 8'hB7, 4, 1, 1, 5, 1));
        tv.push_back(mk(8'h00, 1, 0, 0, 0, 0, 8'hB7, 4, 1, 1, 5, 1));
        tv.push_back(mk(8'h00, 0, 1, 4, 0, rl(8'h00, 8'h00, 2, 8'h11),
                        8'h00, 4, 0, 0, 4, 2));
        tv.push_back(mk(8'h00, 1, 1, 4, 0, rl(8'h00, 8'h00, 3, 8'h22),
                        8'h11, 2, 1, 0, 4, 2));
        tv.push_back(mk(8'h00, 0, 1, 2, 1, rl(8'h00, 8'h00, 7, 8'h55),
                        8'h00, 2, 0, 0, 2, 3));
        tv.push_back(mk(8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 2, 3));
        tv.push_back(mk(8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1, 1, 2, 3));
        tv.push_back(mk(8'h00, 0, 0, 0, 0, 0, 8'h91, 5, 1, 0, 0, 4));
        foreach (tv[i]) cyc(tv[i]);

        // Mid-operation reset discards the table
        do_reset(1);
        cyc(mk(8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));

        // Ping-pong S0<->S1 for 17 transitions; 4-bit counter wraps to 1
        cyc(mk(8'h00, 0, 1, 0, 0, rl(8'h00, 8'h00, 1, 8'hA1),
               8'h00, 0, 0, 0, 0, 0));
        cyc(mk(8'h00, 0, 1, 1, 0, rl(8'h00, 8'h00, 0, 8'hA0),
               8'hA1, 1, 1, 0, 0, 0));
        for (int i = 0; i < 17; i++) begin
            s = 3'(i % 2);
            cyc(mk(8'($urandom), 1, 0, 0, 0, 0,
                   (s == 3'd0) ? 8'hA1 : 8'hA0, 3'd1 - s, 1, 0, s,
                   16'(i)));
        end
        cyc(mk(8'h5A, 0, 0, 0, 0, 0, 8'hA0, 0, 1, 0, 1, 17));

        // Reset in the middle of operation from state 1
        do_reset(1);
        cyc(mk(8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        cyc(mk(8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
